// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_ILL    = 2'd0;
    localparam logic [1:0] CAUSE_ECALL  = 2'd1;
    localparam logic [1:0] CAUSE_INT    = 2'd2;
    localparam logic [1:0] CAUSE_BUSERR = 2'd3;

endpackage

// File: rtl/mc_sequencer_if.sv
// Decoder, memory handshake and datapath control bundle of the sequencer.
interface mc_sequencer_if;

    logic       is_load;
    logic       is_store;
    logic       reg_write_dec;
    logic       ill_instr;
    logic       ecall;
    logic       mret;
    logic       INT0;
    logic       imem_ack;
    logic       dmem_ack;

    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_ce;
    logic       reg_we;
    logic       trap_take;
    logic       trap_ret;
    logic [1:0] cause;
    logic [2:0] state;

    modport master (
        input  is_load, is_store, reg_write_dec, ill_instr, ecall, mret,
               INT0, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_ce, reg_we,
               trap_take, trap_ret, cause, state
    );

    modport slave (
        output is_load, is_store, reg_write_dec, ill_instr, ecall, mret,
               INT0, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_ce, reg_we,
               trap_take, trap_ret, cause, state
    );

endinterface

// File: rtl/mc_seq_watchdog.sv
// Memory wait-cycle counter; flags expiry on the last allowed unacked cycle.
module mc_seq_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Any state change restarts the window, so FETCH and MEM each get a full budget.
    always_comb begin
        count_next = count_reg;
        if (restart) begin
            count_next = '0;
        end else if (active && !ack) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    assign expired = active & ~ack & (count_reg == LIMIT);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB plus trap entry/exit.
// Optional bus-timeout trap enabled by defining MC_SEQ_TIMEOUT_EN.
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    mc_sequencer_if.master bus
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 2..65535");
    end

    state_t     state_reg;
    state_t     state_next;
    logic       int_pend_reg;
    logic       int_pend_next;
    logic       mie_reg;
    logic       mie_next;
    logic       int0_q_reg;
    logic [1:0] cause_reg;
    logic [1:0] cause_next;
    logic       int_rise;
    logic       int_clr;
    logic       timeout_hit;

    logic       imem_req_c;
    logic       dmem_req_c;
    logic       dmem_we_c;
    logic       ir_we_c;
    logic       pc_ce_c;
    logic       reg_we_c;
    logic       trap_take_c;
    logic       trap_ret_c;
    logic [1:0] cause_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_BOOT;
            int_pend_reg <= 1'b0;
            mie_reg      <= 1'b1;
            int0_q_reg   <= 1'b0;
            cause_reg    <= CAUSE_ILL;
        end else begin
            state_reg    <= state_next;
            int_pend_reg <= int_pend_next;
            mie_reg      <= mie_next;
            int0_q_reg   <= bus.INT0;
            cause_reg    <= cause_next;
        end
    end

    assign int_rise = bus.INT0 & ~int0_q_reg;
    // A new edge on the clearing cycle must survive, so set dominates clear.
    assign int_pend_next = int_rise | (int_pend_reg & ~int_clr);

    always_comb begin
        state_next  = state_reg;
        mie_next    = mie_reg;
        cause_next  = cause_reg;
        int_clr     = 1'b0;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_ce_c     = 1'b0;
        reg_we_c    = 1'b0;
        trap_take_c = 1'b0;
        trap_ret_c  = 1'b0;
        cause_c     = 2'd0;

        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (int_pend_reg && mie_reg) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_INT;
                end else begin
                    imem_req_c = 1'b1;
                    if (bus.imem_ack) begin
                        ir_we_c    = 1'b1;
                        state_next = ST_DECODE;
                    end else if (timeout_hit) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_BUSERR;
                    end
                end
            end
            ST_DECODE: begin
                if (bus.ill_instr) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILL;
                end else if (bus.ecall) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ECALL;
                end else if (bus.mret) begin
                    trap_ret_c = 1'b1;
                    pc_ce_c    = 1'b1;
                    mie_next   = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.is_load || bus.is_store) begin
                    state_next = ST_MEM;
                end else begin
                    pc_ce_c    = 1'b1;
                    reg_we_c   = bus.reg_write_dec;
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = bus.is_store;
                if (bus.dmem_ack) begin
                    if (bus.is_store) begin
                        pc_ce_c    = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_BUSERR;
                end
            end
            ST_WB: begin
                reg_we_c   = 1'b1;
                pc_ce_c    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                trap_take_c = 1'b1;
                pc_ce_c     = 1'b1;
                cause_c     = cause_reg;
                mie_next    = 1'b0;
                int_clr     = (cause_reg == CAUSE_INT);
                state_next  = ST_FETCH;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

`ifdef MC_SEQ_TIMEOUT_EN
    logic wd_active;
    logic wd_ack;
    logic wd_restart;

    assign wd_active  = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign wd_ack     = (state_reg == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
    assign wd_restart = (state_next != state_reg);

    mc_seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .ack     (wd_ack),
        .restart (wd_restart),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.imem_req  = imem_req_c;
    assign bus.dmem_req  = dmem_req_c;
    assign bus.dmem_we   = dmem_we_c;
    assign bus.ir_we     = ir_we_c;
    assign bus.pc_ce     = pc_ce_c;
    assign bus.reg_we    = reg_we_c;
    assign bus.trap_take = trap_take_c;
    assign bus.trap_ret  = trap_ret_c;
    assign bus.cause     = cause_c;
    assign bus.state     = state_reg;

endmodule
